// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of a single iCE40 4kb block RAM.
// Optional burst-lock priority is enabled by defining BRAM_ARB_LOCK_EN.

module bram #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
) (
    input  logic               i_wclk,
    input  logic               i_wr_en,
    input  logic [ADDR_SZ-1:0] i_waddr,
    input  logic [DATA_SZ-1:0] i_wdata,
    input  logic               i_rclk,
    input  logic               i_rd_en,
    input  logic [ADDR_SZ-1:0] i_raddr,
    output logic [DATA_SZ-1:0] o_rdata
);
    logic [DATA_SZ-1:0] mem [2**ADDR_SZ];
    logic [DATA_SZ-1:0] rdata_q;

    always_ff @(posedge i_wclk) begin
        if (i_wr_en) mem[i_waddr] <= i_wdata;
    end

    // Read port holds its last word whenever rd_en is low.
    always_ff @(posedge i_rclk) begin
        if (i_rd_en) rdata_q <= mem[i_raddr];
    end

    assign o_rdata = rdata_q;
endmodule

module bram_arbiter #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_a_req,
    input  logic               i_a_wr,
    input  logic [ADDR_SZ-1:0] i_a_addr,
    input  logic [DATA_SZ-1:0] i_a_wdata,
    output logic               o_a_ack,
    output logic               o_a_rvalid,
    output logic [DATA_SZ-1:0] o_a_rdata,
`ifdef BRAM_ARB_LOCK_EN
    input  logic               i_a_lock,
    input  logic               i_b_lock,
`endif
    input  logic               i_b_req,
    input  logic               i_b_wr,
    input  logic [ADDR_SZ-1:0] i_b_addr,
    input  logic [DATA_SZ-1:0] i_b_wdata,
    output logic               o_b_ack,
    output logic               o_b_rvalid,
    output logic [DATA_SZ-1:0] o_b_rdata
);
    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_t;

    req_t               last_grant_q, last_grant_d;
    req_t               owner_q, owner_d;
    req_t               favor;
    logic               rd_pend_q, rd_pend_d;
    logic [DATA_SZ-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_SZ-1:0] b_rdata_q, b_rdata_d;
    logic               lock_q, lock_d;

    logic               a_ack, b_ack, any_ack;
    logic               win_wr;
    logic [ADDR_SZ-1:0] win_addr;
    logic [DATA_SZ-1:0] win_wdata;
    logic               ram_wr_en, ram_rd_en;
    logic [DATA_SZ-1:0] ram_rdata;
    logic               a_rvalid, b_rvalid;

    // A held lock keeps priority with the previous winner; otherwise alternate.
    always_comb begin
        favor = (last_grant_q == REQ_A) ? REQ_B : REQ_A;
        if (lock_q) favor = last_grant_q;
    end

    always_comb begin
        a_ack = 1'b0;
        b_ack = 1'b0;
        if (!i_rst) begin
            if (i_a_req && i_b_req) begin
                a_ack = (favor == REQ_A);
                b_ack = (favor == REQ_B);
            end else begin
                a_ack = i_a_req;
                b_ack = i_b_req;
            end
        end
    end

    assign any_ack   = a_ack | b_ack;
    assign win_wr    = a_ack ? i_a_wr    : i_b_wr;
    assign win_addr  = a_ack ? i_a_addr  : i_b_addr;
    assign win_wdata = a_ack ? i_a_wdata : i_b_wdata;
    assign ram_wr_en = any_ack &  win_wr;
    assign ram_rd_en = any_ack & ~win_wr;

    bram #(
        .DATA_SZ(DATA_SZ),
        .ADDR_SZ(ADDR_SZ)
    ) u_bram (
        .i_wclk (i_clk),
        .i_wr_en(ram_wr_en),
        .i_waddr(win_addr),
        .i_wdata(win_wdata),
        .i_rclk (i_clk),
        .i_rd_en(ram_rd_en),
        .i_raddr(win_addr),
        .o_rdata(ram_rdata)
    );

    // Masking with reset drops a response whose read was granted just before reset.
    assign a_rvalid = rd_pend_q && (owner_q == REQ_A) && !i_rst;
    assign b_rvalid = rd_pend_q && (owner_q == REQ_B) && !i_rst;

    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        rd_pend_d    = ram_rd_en;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        if (any_ack) last_grant_d = a_ack ? REQ_A : REQ_B;
        if (ram_rd_en) owner_d = a_ack ? REQ_A : REQ_B;
        if (a_rvalid) a_rdata_d = ram_rdata;
        if (b_rvalid) b_rdata_d = ram_rdata;
    end

`ifdef BRAM_ARB_LOCK_EN
    // Lock ends when the holder is granted without lock or idles for a cycle.
    always_comb begin
        lock_d = lock_q;
        if (any_ack) begin
            lock_d = a_ack ? i_a_lock : i_b_lock;
        end else if (lock_q) begin
            if ((last_grant_q == REQ_A) ? !i_a_req : !i_b_req) lock_d = 1'b0;
        end
    end
`else
    always_comb begin
        lock_d = 1'b0;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant_q <= REQ_B;
            owner_q      <= REQ_A;
            rd_pend_q    <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            lock_q       <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            rd_pend_q    <= rd_pend_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            lock_q       <= lock_d;
        end
    end

    assign o_a_ack    = a_ack;
    assign o_b_ack    = b_ack;
    assign o_a_rvalid = a_rvalid;
    assign o_b_rvalid = b_rvalid;
    assign o_a_rdata  = a_rvalid ? ram_rdata : a_rdata_q;
    assign o_b_rdata  = b_rvalid ? ram_rdata : b_rdata_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed vector table plus randomized traffic against a
// transaction-level model (define BRAM_ARB_LOCK_EN to include the burst-lock rows).

module tb_bram_arbiter;
    localparam int DATA_SZ = 16;
    localparam int ADDR_SZ = 8;

    localparam logic [2:0] IDLE = 3'b000;
    localparam logic [2:0] RD   = 3'b100;
    localparam logic [2:0] WR   = 3'b110;
    localparam logic [2:0] RDL  = 3'b101;
    localparam logic [15:0] AA  = 16'hAAAA;
    localparam logic [15:0] BB  = 16'hBBBB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_req, a_wr, a_lock, b_req, b_wr, b_lock;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, b_ack, a_rvalid, b_rvalid;
    logic [15:0] a_rdata, b_rdata;

    int checks = 0;
    int errors = 0;

    bram_arbiter #(
        .DATA_SZ(DATA_SZ),
        .ADDR_SZ(ADDR_SZ)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_a_req   (a_req),
        .i_a_wr    (a_wr),
        .i_a_addr  (a_addr),
        .i_a_wdata (a_wdata),
        .o_a_ack   (a_ack),
        .o_a_rvalid(a_rvalid),
        .o_a_rdata (a_rdata),
`ifdef BRAM_ARB_LOCK_EN
        .i_a_lock  (a_lock),
        .i_b_lock  (b_lock),
`endif
        .i_b_req   (b_req),
        .i_b_wr    (b_wr),
        .i_b_addr  (b_addr),
        .i_b_wdata (b_wdata),
        .o_b_ack   (b_ack),
        .o_b_rvalid(b_rvalid),
        .o_b_rdata (b_rdata)
    );

    typedef struct {
        logic        rst;
        logic        a_req;
        logic        a_wr;
        logic        a_lock;
        logic [7:0]  a_addr;
        logic [15:0] a_wd;
        logic        b_req;
        logic        b_wr;
        logic        b_lock;
        logic [7:0]  b_addr;
        logic [15:0] b_wd;
        logic        ea_ack;
        logic        eb_ack;
        logic        ea_rv;
        logic        eb_rv;
        logic [15:0] ea_rd;
        logic [15:0] eb_rd;
    } vec_t;

    // Transaction-level reference: memory image, who went last, one outstanding read.
    logic [15:0] mem [256];
    logic        m_last_b = 1'b1;
    logic        m_lock = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_pend_b = 1'b0;
    logic [15:0] m_pend_data = 16'h0;
    logic [15:0] m_hold_a = 16'h0;
    logic [15:0] m_hold_b = 16'h0;

    function automatic vec_t row(input logic r, input logic [2:0] ac, input logic [7:0] aa,
                                 input logic [15:0] ad, input logic [2:0] bc, input logic [7:0] ba,
                                 input logic [15:0] bd, input logic [3:0] ef,
                                 input logic [15:0] erda, input logic [15:0] erdb);
        vec_t v;
        v.rst = r;
        {v.a_req, v.a_wr, v.a_lock} = ac;
        v.a_addr = aa;
        v.a_wd = ad;
        {v.b_req, v.b_wr, v.b_lock} = bc;
        v.b_addr = ba;
        v.b_wd = bd;
        {v.ea_ack, v.eb_ack, v.ea_rv, v.eb_rv} = ef;
        v.ea_rd = erda;
        v.eb_rd = erdb;
        return v;
    endfunction

    function automatic void model_grant(output logic ga, output logic gb);
        logic pick_b;
        ga = 1'b0;
        gb = 1'b0;
        if (!rst) begin
            if (a_req && b_req) begin
                pick_b = m_lock ? m_last_b : !m_last_b;
                ga = !pick_b;
                gb = pick_b;
            end else begin
                ga = a_req;
                gb = b_req;
            end
        end
    endfunction

    function automatic void model_update(input logic ga, input logic gb);
        logic        w;
        logic [7:0]  ad;
        if (rst) begin
            m_pend = 1'b0;
            m_last_b = 1'b1;
            m_lock = 1'b0;
            m_hold_a = 16'h0;
            m_hold_b = 16'h0;
        end else begin
            if (m_pend) begin
                if (m_pend_b) m_hold_b = m_pend_data;
                else m_hold_a = m_pend_data;
            end
            m_pend = 1'b0;
            if (ga || gb) begin
                m_last_b = gb;
                m_lock = gb ? b_lock : a_lock;
                w = gb ? b_wr : a_wr;
                ad = gb ? b_addr : a_addr;
                if (w) begin
                    mem[ad] = gb ? b_wdata : a_wdata;
                end else begin
                    m_pend = 1'b1;
                    m_pend_b = gb;
                    m_pend_data = mem[ad];
                end
            end else if (m_lock && !(m_last_b ? b_req : a_req)) begin
                m_lock = 1'b0;
            end
        end
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst = v.rst;
        a_req = v.a_req;
        a_wr = v.a_wr;
        a_lock = v.a_lock;
        a_addr = v.a_addr;
        a_wdata = v.a_wd;
        b_req = v.b_req;
        b_wr = v.b_wr;
        b_lock = v.b_lock;
        b_addr = v.b_addr;
        b_wdata = v.b_wd;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive, sample mid-cycle, then advance the model on the rising edge.
    task automatic run_cycle(input vec_t v, input bit use_table, input string tag,
                             output logic ga, output logic gb);
        logic        era, erb;
        logic [15:0] erda, erdb;
        applyStimulus(v);
        @(negedge clk);
        model_grant(ga, gb);
        if (use_table) begin
            checkOutput($sformatf("%s a_ack", tag), 16'(a_ack), 16'(v.ea_ack));
            checkOutput($sformatf("%s b_ack", tag), 16'(b_ack), 16'(v.eb_ack));
            checkOutput($sformatf("%s a_rvalid", tag), 16'(a_rvalid), 16'(v.ea_rv));
            checkOutput($sformatf("%s b_rvalid", tag), 16'(b_rvalid), 16'(v.eb_rv));
            if (v.ea_rv) checkOutput($sformatf("%s a_rdata", tag), a_rdata, v.ea_rd);
            if (v.eb_rv) checkOutput($sformatf("%s b_rdata", tag), b_rdata, v.eb_rd);
        end else begin
            era = m_pend && !m_pend_b && !rst;
            erb = m_pend && m_pend_b && !rst;
            erda = era ? m_pend_data : m_hold_a;
            erdb = erb ? m_pend_data : m_hold_b;
            checkOutput($sformatf("%s a_ack", tag), 16'(a_ack), 16'(ga));
            checkOutput($sformatf("%s b_ack", tag), 16'(b_ack), 16'(gb));
            checkOutput($sformatf("%s a_rvalid", tag), 16'(a_rvalid), 16'(era));
            checkOutput($sformatf("%s b_rvalid", tag), 16'(b_rvalid), 16'(erb));
            checkOutput($sformatf("%s a_rdata", tag), a_rdata, erda);
            checkOutput($sformatf("%s b_rdata", tag), b_rdata, erdb);
        end
        @(posedge clk);
        model_update(ga, gb);
        #1;
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        cur;
        logic        ga, gb;
        logic        a_busy, b_busy;
        logic [15:0] pd;

        applyStimulus(row(1'b1, IDLE, 8'h0, 16'h0, IDLE, 8'h0, 16'h0, 4'b0, 16'h0, 16'h0));
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] preload memory image");
        run_cycle(row(1'b1, IDLE, 8'h0, 16'h0, IDLE, 8'h0, 16'h0, 4'b0, 16'h0, 16'h0), 1'b0, "pre_rst", ga, gb);
        for (int i = 0; i < 256; i++) begin
            pd = {8'(i), 8'(i) ^ 8'h5A};
            if (i == 1) pd = AA;
            if (i == 2) pd = BB;
            run_cycle(row(1'b0, WR, 8'(i), pd, IDLE, 8'h0, 16'h0, 4'b0, 16'h0, 16'h0), 1'b0, "preload", ga, gb);
        end

        // Directed vectors; expected flags are {a_ack, b_ack, a_rvalid, b_rvalid}.
        tbl.push_back(row(1'b1, RD,   8'h01, 16'h0,    RD,   8'h02, 16'h0, 4'b0000, 16'h0,    16'h0));
        tbl.push_back(row(1'b0, WR,   8'h10, 16'h1234, IDLE, 8'h00, 16'h0, 4'b1000, 16'h0,    16'h0));
        tbl.push_back(row(1'b0, RD,   8'h10, 16'h0,    IDLE, 8'h00, 16'h0, 4'b1000, 16'h0,    16'h0));
        tbl.push_back(row(1'b0, IDLE, 8'h00, 16'h0,    IDLE, 8'h00, 16'h0, 4'b0010, 16'h1234, 16'h0));
        tbl.push_back(row(1'b1, IDLE, 8'h00, 16'h0,    IDLE, 8'h00, 16'h0, 4'b0000, 16'h0,    16'h0));
        tbl.push_back(row(1'b0, RD,   8'h01, 16'h0,    RD,   8'h02, 16'h0, 4'b1000, 16'h0,    16'h0));
        tbl.push_back(row(1'b0, IDLE, 8'h00, 16'h0,    RD,   8'h02, 16'h0, 4'b0110, AA,       16'h0));
        tbl.push_back(row(1'b0, IDLE, 8'h00, 16'h0,    IDLE, 8'h00, 16'h0, 4'b0001, 16'h0,    BB));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(row(1'b0, RD, 8'h01, 16'h0, RD, 8'h02, 16'h0,
                              {i % 2 == 0, i % 2 == 1, i % 2 == 1, i > 0 && i % 2 == 0}, AA, BB));
        end
        tbl.push_back(row(1'b0, WR,   8'h20, 16'h5555, IDLE, 8'h00, 16'h0, 4'b1001, 16'h0,    BB));
        tbl.push_back(row(1'b0, IDLE, 8'h00, 16'h0,    RD,   8'h20, 16'h0, 4'b0100, 16'h0,    16'h0));
        tbl.push_back(row(1'b0, IDLE, 8'h00, 16'h0,    IDLE, 8'h00, 16'h0, 4'b0001, 16'h0,    16'h5555));
        tbl.push_back(row(1'b0, RD,   8'h10, 16'h0,    IDLE, 8'h00, 16'h0, 4'b1000, 16'h0,    16'h0));
        tbl.push_back(row(1'b1, IDLE, 8'h00, 16'h0,    IDLE, 8'h00, 16'h0, 4'b0000, 16'h0,    16'h0));
        tbl.push_back(row(1'b0, RD,   8'h01, 16'h0,    RD,   8'h02, 16'h0, 4'b1000, 16'h0,    16'h0));
        tbl.push_back(row(1'b0, IDLE, 8'h00, 16'h0,    IDLE, 8'h00, 16'h0, 4'b0010, AA,       16'h0));
`ifdef BRAM_ARB_LOCK_EN
        tbl.push_back(row(1'b0, RD,   8'h01, 16'h0,    RDL,  8'h02, 16'h0, 4'b0100, 16'h0,    16'h0));
        tbl.push_back(row(1'b0, RD,   8'h01, 16'h0,    RDL,  8'h02, 16'h0, 4'b0101, 16'h0,    BB));
        tbl.push_back(row(1'b0, RD,   8'h01, 16'h0,    RDL,  8'h02, 16'h0, 4'b0101, 16'h0,    BB));
        tbl.push_back(row(1'b0, RD,   8'h01, 16'h0,    RD,   8'h02, 16'h0, 4'b0101, 16'h0,    BB));
        tbl.push_back(row(1'b0, RD,   8'h01, 16'h0,    RD,   8'h02, 16'h0, 4'b1001, 16'h0,    BB));
        tbl.push_back(row(1'b0, IDLE, 8'h00, 16'h0,    IDLE, 8'h00, 16'h0, 4'b0010, AA,       16'h0));
`endif
        $display("[TB] directed vectors: %0d rows", tbl.size());
        foreach (tbl[i]) begin
            run_cycle(tbl[i], 1'b1, $sformatf("row%0d", i), ga, gb);
        end

        $display("[TB] randomized traffic");
        cur = row(1'b0, IDLE, 8'h0, 16'h0, IDLE, 8'h0, 16'h0, 4'b0, 16'h0, 16'h0);
        a_busy = 1'b0;
        b_busy = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!a_busy && $urandom_range(0, 99) < 65) begin
                a_busy = 1'b1;
                cur.a_wr = ($urandom_range(0, 2) == 0);
                cur.a_addr = 8'($urandom);
                cur.a_wd = 16'($urandom);
`ifdef BRAM_ARB_LOCK_EN
                cur.a_lock = ($urandom_range(0, 3) == 0);
`endif
            end
            if (!b_busy && $urandom_range(0, 99) < 65) begin
                b_busy = 1'b1;
                cur.b_wr = ($urandom_range(0, 2) == 0);
                cur.b_addr = 8'($urandom);
                cur.b_wd = 16'($urandom);
`ifdef BRAM_ARB_LOCK_EN
                cur.b_lock = ($urandom_range(0, 3) == 0);
`endif
            end
            cur.a_req = a_busy;
            cur.b_req = b_busy;
            cur.rst = ($urandom_range(0, 49) == 0);
            run_cycle(cur, 1'b0, "rand", ga, gb);
            if (ga) a_busy = 1'b0;
            if (gb) b_busy = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
